// File: rtl/lfsr_top.sv
// Dual Fibonacci LFSR: a fixed maximal-length tap set chosen by WIDTH, plus one
// driven by a runtime tap mask. Both advance together; a select picks the output.
module lfsr_top #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             use_config_lfsr,
    input  logic [WIDTH-1:0] config_taps,
    output logic [WIDTH-1:0] lfsr_out
);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
            $error("lfsr_top: WIDTH must be in 2..16");
        end
    endgenerate

    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    // Maximal-length tap sets; tap k (1-indexed) lands on mask bit k-1.
    function automatic logic [15:0] static_mask16(input int w);
        logic [15:0] m;
        case (w)
            2:       m = 16'h0003;
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    localparam logic [15:0]      STATIC_MASK16 = static_mask16(WIDTH);
    localparam logic [WIDTH-1:0] STATIC_MASK   = STATIC_MASK16[WIDTH-1:0];

    // An all-zero state would stick forever, so it reloads the seed instead.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] mask);
        if (s == '0) begin
            return SEED;
        end
        return {s[WIDTH-2:0], ^(s & mask)};
    endfunction

    logic [WIDTH-1:0] s_static_q, s_static_d;
    logic [WIDTH-1:0] s_cfg_q,    s_cfg_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        s_static_d = s_static_q;
        s_cfg_d    = s_cfg_q;
        if (enable) begin
            s_static_d = lfsr_step(s_static_q, STATIC_MASK);
            s_cfg_d    = lfsr_step(s_cfg_q, config_taps);
        end
    end

    // NOTE: state registers use non-blocking assignment so both LFSRs update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_static_q <= SEED;
            s_cfg_q    <= SEED;
        end else begin
            s_static_q <= s_static_d;
            s_cfg_q    <= s_cfg_d;
        end
    end

    assign lfsr_out = use_config_lfsr ? s_cfg_q : s_static_q;

endmodule

// File: tb/tb_lfsr_top.sv
// Directed bench for lfsr_top: WIDTH=3 sequences, select, hold, lockup, async
// reset, and a WIDTH=8 period run on a second instance.
module tb_lfsr_top;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       use_cfg;
    logic [2:0] taps;
    logic [2:0] out3;
    logic       en8;
    logic [7:0] out8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_top #(.WIDTH(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .use_config_lfsr (use_cfg),
        .config_taps     (taps),
        .lfsr_out        (out3)
    );

    lfsr_top #(.WIDTH(8)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .enable          (en8),
        .use_config_lfsr (1'b0),
        .config_taps     (8'h00),
        .lfsr_out        (out8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset away from any clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b1;
        use_cfg = 1'b0;
        taps    = 3'b110;
        en8     = 1'b0;
        tick();
        checks++;
        if (out3 !== 3'b001) begin
            errors++;
            $display("FAIL reset_static: got %b expected %b", out3, 3'b001);
        end
        use_cfg = 1'b1;
        #1;
        checks++;
        if (out3 !== 3'b001) begin
            errors++;
            $display("FAIL reset_cfg: got %b expected %b", out3, 3'b001);
        end
        checks++;
        if (out8 !== 8'h01) begin
            errors++;
            $display("FAIL reset_w8: got %h expected %h", out8, 8'h01);
        end
        reset   = 1'b0;
        use_cfg = 1'b0;
    endtask

    task automatic test_static_seq();
        logic [2:0] exp_seq [7] = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
        pulse_reset();
        use_cfg = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (out3 !== exp_seq[i]) begin
                errors++;
                $display("FAIL static_seq[%0d]: got %b expected %b", i, out3, exp_seq[i]);
            end
        end
    endtask

    task automatic test_cfg_seq();
        logic [2:0] exp_a [7] = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
        logic [2:0] exp_b [7] = '{3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100, 3'b001};
        use_cfg = 1'b1;
        taps    = 3'b110;
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (out3 !== exp_a[i]) begin
                errors++;
                $display("FAIL cfg110_seq[%0d]: got %b expected %b", i, out3, exp_a[i]);
            end
        end
        taps = 3'b101;
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (out3 !== exp_b[i]) begin
                errors++;
                $display("FAIL cfg101_seq[%0d]: got %b expected %b", i, out3, exp_b[i]);
            end
        end
    endtask

    task automatic test_select_toggle();
        use_cfg = 1'b0;
        taps    = 3'b101;
        pulse_reset();
        repeat (4) tick();
        checks++;
        if (out3 !== 3'b111) begin
            errors++;
            $display("FAIL sel_static4: got %b expected %b", out3, 3'b111);
        end
        use_cfg = 1'b1;
        #1;
        checks++;
        if (out3 !== 3'b101) begin
            errors++;
            $display("FAIL sel_cfg101_4: got %b expected %b", out3, 3'b101);
        end
        use_cfg = 1'b0;
        #1;
        checks++;
        if (out3 !== 3'b111) begin
            errors++;
            $display("FAIL sel_back_static: got %b expected %b", out3, 3'b111);
        end
        taps = 3'b110;
        pulse_reset();
        repeat (4) tick();
        use_cfg = 1'b1;
        #1;
        checks++;
        if (out3 !== 3'b111) begin
            errors++;
            $display("FAIL sel_cfg110_4: got %b expected %b", out3, 3'b111);
        end
        use_cfg = 1'b0;
    endtask

    task automatic test_hold();
        use_cfg = 1'b0;
        taps    = 3'b101;
        pulse_reset();
        repeat (3) tick();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out3 !== 3'b011) begin
                errors++;
                $display("FAIL hold_static[%0d]: got %b expected %b", i, out3, 3'b011);
            end
        end
        use_cfg = 1'b1;
        #1;
        checks++;
        if (out3 !== 3'b110) begin
            errors++;
            $display("FAIL hold_cfg: got %b expected %b", out3, 3'b110);
        end
        use_cfg = 1'b0;
        enable  = 1'b1;
        tick();
        checks++;
        if (out3 !== 3'b111) begin
            errors++;
            $display("FAIL hold_resume: got %b expected %b", out3, 3'b111);
        end
    endtask

    task automatic test_cfg_change();
        use_cfg = 1'b1;
        taps    = 3'b110;
        pulse_reset();
        repeat (2) tick();
        checks++;
        if (out3 !== 3'b101) begin
            errors++;
            $display("FAIL chg_pre: got %b expected %b", out3, 3'b101);
        end
        taps = 3'b101;
        tick();
        checks++;
        if (out3 !== 3'b010) begin
            errors++;
            $display("FAIL chg_first: got %b expected %b", out3, 3'b010);
        end
        tick();
        checks++;
        if (out3 !== 3'b100) begin
            errors++;
            $display("FAIL chg_second: got %b expected %b", out3, 3'b100);
        end
    endtask

    task automatic test_lockup();
        logic [2:0] exp_seq [5] = '{3'b010, 3'b100, 3'b000, 3'b001, 3'b010};
        use_cfg = 1'b1;
        taps    = 3'b000;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out3 !== exp_seq[i]) begin
                errors++;
                $display("FAIL lockup[%0d]: got %b expected %b", i, out3, exp_seq[i]);
            end
        end
        use_cfg = 1'b0;
        #1;
        checks++;
        if (out3 !== 3'b110) begin
            errors++;
            $display("FAIL lockup_static: got %b expected %b", out3, 3'b110);
        end
        taps = 3'b110;
    endtask

    task automatic test_async_reset();
        use_cfg = 1'b0;
        pulse_reset();
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out3 !== 3'b001) begin
            errors++;
            $display("FAIL async_static: got %b expected %b", out3, 3'b001);
        end
        use_cfg = 1'b1;
        #1;
        checks++;
        if (out3 !== 3'b001) begin
            errors++;
            $display("FAIL async_cfg: got %b expected %b", out3, 3'b001);
        end
        reset   = 1'b0;
        use_cfg = 1'b0;
        tick();
        checks++;
        if (out3 !== 3'b010) begin
            errors++;
            $display("FAIL async_resume: got %b expected %b", out3, 3'b010);
        end
    endtask

    task automatic test_period8();
        logic [7:0] exp_head [5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        pulse_reset();
        en8 = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            if (i <= 5) begin
                checks++;
                if (out8 !== exp_head[i-1]) begin
                    errors++;
                    $display("FAIL w8_head[%0d]: got %h expected %h", i, out8, exp_head[i-1]);
                end
            end
            if (i < 255) begin
                checks++;
                if (out8 === 8'h01 || out8 === 8'h00) begin
                    errors++;
                    $display("FAIL w8_early_repeat[%0d]: got %h expected not seed/zero", i, out8);
                end
            end else begin
                checks++;
                if (out8 !== 8'h01) begin
                    errors++;
                    $display("FAIL w8_period: got %h expected %h", out8, 8'h01);
                end
            end
        end
        en8 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_static_seq();
        test_cfg_seq();
        test_select_toggle();
        test_hold();
        test_cfg_change();
        test_lockup();
        test_async_reset();
        test_period8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
